// File: rtl/qos_config_bank.sv
// qos_config_bank: double-buffered QoS configuration store with validated commit gated on engine idle
module qos_config_bank #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT = 64,
  parameter int TABLE_SIZE = 8,
  parameter int MAX_MAG_UMBRAL = 16,
  parameter int TIPOS_ROUND_ROBIN = 3,
  parameter int DATA_BITS = 8,
  parameter int VERSION_BITS = 4,
  localparam int WW = $clog2(MAX_WEIGHT),
  localparam int UW = $clog2(MAX_MAG_UMBRAL),
  localparam int SW = $clog2(TIPOS_ROUND_ROBIN),
  localparam int QW = $clog2(QUEUE_QUANTITY),
  localparam int N = 3 + QUEUE_QUANTITY + 2 * TABLE_SIZE,
  localparam int AW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic wr_err,
  input  logic [AW-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic commit_req,
  input  logic commit_abort,
  input  logic engine_idle,
  output logic busy,
  output logic commit_done,
  output logic commit_err,
  output logic [VERSION_BITS-1:0] version,
  output logic [SW-1:0] seleccion_roundRobin_out,
  output logic [QUEUE_QUANTITY*WW-1:0] pesos_out,
  output logic [TABLE_SIZE*WW-1:0] pesosArbitraje_out,
  output logic [TABLE_SIZE*QW-1:0] selecciones_out,
  output logic [UW-1:0] umbral_min_out,
  output logic [UW-1:0] umbral_max_out
);
  localparam int Q = QUEUE_QUANTITY;
  localparam int T = TABLE_SIZE;
  function automatic logic [T*QW-1:0] sl_def();
    logic [T*QW-1:0] r = '0;
    for (int k = 0; k < T; k++) r[k*QW +: QW] = QW'(k % Q);
    return r;
  endfunction
  localparam logic [T*QW-1:0] SL_DEF = sl_def();
  localparam logic [Q*WW-1:0] PES_DEF = {Q{WW'(1)}};
  localparam logic [T*WW-1:0] PA_DEF = {T{WW'(1)}};
  localparam logic [UW-1:0] MAX_DEF = UW'(MAX_MAG_UMBRAL - 1);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_n;
  logic [SW-1:0] sh_sel;
  logic [Q*WW-1:0] sh_pes;
  logic [T*WW-1:0] sh_pa;
  logic [T*QW-1:0] sh_sl;
  logic [UW-1:0] sh_min, sh_max;
  logic [31:0] wa, ra;
  logic wr_en, addr_ok, ok, copy, unused;
  assign wa = 32'(wr_addr);
  assign ra = 32'(rd_addr);
  assign wr_ready = state == IDLE;
  assign busy = state == PEND;
  assign wr_en = wr_valid && wr_ready;
  assign addr_ok = wa < N;
  assign copy = busy && !commit_abort && engine_idle;
  assign unused = ^wr_data;
  always_comb begin
    ok = 32'(sh_sel) < TIPOS_ROUND_ROBIN && sh_min <= sh_max;
    for (int i = 0; i < Q; i++) ok = ok && |sh_pes[i*WW +: WW];
    for (int i = 0; i < T; i++) ok = ok && |sh_pa[i*WW +: WW];
  end
  always_comb state_n = state == IDLE ? (commit_req && !wr_valid && ok ? PEND : IDLE)
                                      : (commit_abort || engine_idle ? IDLE : PEND);
  always_comb begin
    rd_data = '0;
    if (ra == 0) rd_data = DATA_BITS'(sh_sel);
    for (int i = 0; i < Q; i++) if (ra == 32'(1 + i)) rd_data = DATA_BITS'(sh_pes[i*WW +: WW]);
    for (int i = 0; i < T; i++) if (ra == 32'(Q + 1 + i)) rd_data = DATA_BITS'(sh_pa[i*WW +: WW]);
    for (int i = 0; i < T; i++) if (ra == 32'(Q + T + 1 + i)) rd_data = DATA_BITS'(sh_sl[i*QW +: QW]);
    if (ra == 32'(Q + 2 * T + 1)) rd_data = DATA_BITS'(sh_min);
    if (ra == 32'(Q + 2 * T + 2)) rd_data = DATA_BITS'(sh_max);
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_sel <= '0;
      sh_pes <= PES_DEF;
      sh_pa <= PA_DEF;
      sh_sl <= SL_DEF;
      sh_min <= '0;
      sh_max <= MAX_DEF;
      seleccion_roundRobin_out <= '0;
      pesos_out <= PES_DEF;
      pesosArbitraje_out <= PA_DEF;
      selecciones_out <= SL_DEF;
      umbral_min_out <= '0;
      umbral_max_out <= MAX_DEF;
      version <= '0;
      wr_err <= 1'b0;
      commit_err <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      wr_err <= wr_en && !addr_ok;
      commit_err <= state == IDLE && commit_req && !wr_valid && !ok;
      commit_done <= copy;
      if (wr_en) begin
        if (wa == 0) sh_sel <= wr_data[SW-1:0];
        for (int i = 0; i < Q; i++) if (wa == 32'(1 + i)) sh_pes[i*WW +: WW] <= wr_data[WW-1:0];
        for (int i = 0; i < T; i++) if (wa == 32'(Q + 1 + i)) sh_pa[i*WW +: WW] <= wr_data[WW-1:0];
        for (int i = 0; i < T; i++) if (wa == 32'(Q + T + 1 + i)) sh_sl[i*QW +: QW] <= wr_data[QW-1:0];
        if (wa == 32'(Q + 2 * T + 1)) sh_min <= wr_data[UW-1:0];
        if (wa == 32'(Q + 2 * T + 2)) sh_max <= wr_data[UW-1:0];
      end
      if (copy) begin
        seleccion_roundRobin_out <= sh_sel;
        pesos_out <= sh_pes;
        pesosArbitraje_out <= sh_pa;
        selecciones_out <= sh_sl;
        umbral_min_out <= sh_min;
        umbral_max_out <= sh_max;
        version <= version + VERSION_BITS'(1);
      end
    end
  end
endmodule

// File: doc/qos_config_bank.md
Name: qos_config_bank

Overview:
- Parametrised, double-buffered QoS configuration store.
- Software fills a shadow register bank through an addressed write port.
- A validated, handshaked commit copies the shadow bank into the active outputs, but only while the arbitration engine reports idle. The active outputs feed the round-robin/arbitration logic.
- Over a single-strobe latch, this block adds: a per-field write port, shadow readback, range validation, a commit FSM gated on engine idle, abort, and a version counter.

Parameters:
- QUEUE_QUANTITY, 4, number of FIFO queues.
- MAX_WEIGHT, 64, weight range. Field width WW = clog2(MAX_WEIGHT).
- TABLE_SIZE, 8, arbitration table entries.
- MAX_MAG_UMBRAL, 16, threshold range. Field width UW = clog2(MAX_MAG_UMBRAL).
- TIPOS_ROUND_ROBIN, 3, number of round-robin modes. Field width SW = clog2(TIPOS_ROUND_ROBIN).
- DATA_BITS, 8, write/read data width. Must be at least max(WW, UW, SW).
- VERSION_BITS, 4, width of the commit counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
- wr_addr  in  AW  shadow register address; AW = clog2(N), N = 3 + QUEUE_QUANTITY + 2*TABLE_SIZE.
- wr_data  in  DATA_BITS  write data; the low field-width bits are used.
- wr_err  out  1  one-cycle pulse when an address ≥ N is written.
- rd_addr  in  AW  shadow readback address.
- rd_data  out  DATA_BITS  combinational shadow readback, zero-extended; 0 when address ≥ N.
- commit_req  in  1  request to apply the shadow bank.
- commit_abort  in  1  cancel a pending commit.
- engine_idle  in  1  arbiter is between packets; copying is safe.
- busy  out  1  commit pending.
- commit_done  out  1  one-cycle pulse on the edge where the active bank updates.
- commit_err  out  1  one-cycle pulse when validation rejects a commit.
- version  out  VERSION_BITS  count of successful commits; wraps.
- seleccion_roundRobin_out  out  SW  active round-robin mode.
- pesos_out  out  QUEUE_QUANTITY*WW  active queue weights; queue i occupies bits [i*WW +: WW].
- pesosArbitraje_out  out  TABLE_SIZE*WW  active table weights.
- selecciones_out  out  TABLE_SIZE*clog2(QUEUE_QUANTITY)  active table queue selections.
- umbral_min_out  out  UW  active minimum threshold.
- umbral_max_out  out  UW  active maximum threshold.

Behaviour:
- Address map:
  - 0: seleccion.
  - 1..Q: pesos[0..Q-1].
  - Q+1..Q+T: pesosArbitraje[0..T-1].
  - Q+T+1..Q+2T: selecciones[0..T-1].
  - Q+2T+1: umbral_min.
  - Q+2T+2: umbral_max.
- Reset (rst=0 at an edge) sets both shadow and active banks to:
  - seleccion = 0;
  - every weight = 1;
  - selecciones[k] = k mod QUEUE_QUANTITY;
  - umbral_min = 0;
  - umbral_max = MAX_MAG_UMBRAL-1.
- Reset also clears version, busy and all pulses, and forces the FSM to IDLE. A reset during PEND discards the pending commit.
- FSM has two states, IDLE and PEND. busy = (state == PEND). wr_ready = (state == IDLE).
- IDLE, write accepted:
  - Valid address: the shadow field updates at that edge and is visible on rd_data the next cycle.
  - Invalid address: no state changes and wr_err pulses the next cycle.
- IDLE, commit_req with wr_valid low: the shadow bank is validated. A commit is rejected if any of these holds:
  - seleccion ≥ TIPOS_ROUND_ROBIN;
  - umbral_min > umbral_max;
  - any weight == 0.
  - Rejected: commit_err pulses the next cycle and the FSM stays in IDLE.
  - Accepted: the FSM moves to PEND.
- IDLE, commit_req together with wr_valid: the write is accepted, commit_req is ignored, and no pulse is generated.
- PEND:
  - Writes are stalled (wr_ready = 0).
  - commit_abort = 1: return to IDLE with no copy and no pulse. Abort has priority over engine_idle in the same cycle.
  - engine_idle = 1 and no abort: at that edge, active ← shadow, version increments, commit_done is high for the following cycle, and the FSM returns to IDLE.
  - This covers engine_idle already high on PEND entry: the copy happens one cycle after the accepted commit_req edge.
- commit_req while in PEND is ignored.
- Active outputs change only on a successful commit or on reset; they are registered and glitch-free.
- version wraps from 2^VERSION_BITS-1 to 0.

Test Plan:
- Reset, then read addresses 0..22 (defaults) → rd_data: 0; 1 ×12; selecciones 0,1,2,3,0,1,2,3; umbral 0 and 15. Active outputs match; version = 0.
- Write addr 1 = 0x05, addr 21 = 3, addr 22 = 12; commit_req with engine_idle = 1 → commit_done one cycle later. pesos_out[5:0] = 5, umbral_min_out = 3, umbral_max_out = 12, version = 1.
- Write addr 21 = 9, addr 22 = 4; commit_req → commit_err pulse; active outputs and version unchanged; busy stays 0.
- Valid commit_req with engine_idle = 0 for 10 cycles → busy = 1, wr_ready = 0, outputs held. Raise engine_idle → copy, commit_done, busy = 0.
- In PEND, assert commit_abort and engine_idle together → no copy, no commit_done, IDLE next cycle. Write to addr 30 → wr_err pulse, no change.
- 16 successful commits → version wraps to 0. Pull rst low while in PEND → defaults restored, busy = 0, no commit_done.
